// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_pkg : shared state encoding and limits for the configurable UART RX
// Revision    : 1.0
// ----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int MIN_PRESCALE = 8;
  localparam int DATA_W_MIN   = 5;
  localparam int DATA_W_MAX   = 9;
  localparam int BIT_CNT_W    = $clog2(DATA_W_MAX + 1);

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sampler : per-bit edge counter with 3-sample majority vote
// Revision        : 1.0
// ----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  enable_i,
  input  logic                  restart_i,
  input  logic                  rx_i,
  output logic                  maj_valid_o,
  output logic                  maj_bit_o,
  output logic                  bit_done_o
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] half;
  logic                  s0_q, s1_q;

  assign half        = prescale_i >> 1;
  assign bit_done_o  = enable_i && (edge_q == prescale_i - CNT_ONE);
  assign maj_valid_o = enable_i && (edge_q == half + CNT_ONE);
  // Third sample is the live bit at the decision point.
  assign maj_bit_o   = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);

  always_comb begin
    edge_d = '0;
    if (enable_i && !restart_i && !bit_done_o) begin
      edge_d = edge_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      edge_q <= edge_d;
      if (enable_i && (edge_q == half - CNT_ONE)) s0_q <= rx_i;
      if (enable_i && (edge_q == half))           s1_q <= rx_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_cfg : runtime-configurable UART receiver (parity, 1/2 stop, break)
// Revision    : 1.0
// ----------------------------------------------------------------------------
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  Data_valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Break_Det,
  output logic                  Busy
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || SYNC_STAGES < 2 || SYNC_STAGES > 3)
  begin : g_bad_params
    $error("uart_rx_cfg: DATA_W or SYNC_STAGES out of range");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);

  rx_state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic                    par_err_q, par_err_d;
  logic                    stop_err_q, stop_err_d;
  logic                    zero_q, zero_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    stop2_q, stop2_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [DATA_W-1:0]       p_data_q, p_data_d;
  logic                    dv_q, dv_d, pe_q, pe_d, se_q, se_d, bd_q, bd_d;
  logic                    samp_en, samp_restart;
  logic                    maj_valid, maj_bit, bit_done;
  logic                    stop_err_now, all_zero;

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .prescale_i (prescale_q),
    .enable_i   (samp_en),
    .restart_i  (samp_restart),
    .rx_i       (rx_s),
    .maj_valid_o(maj_valid),
    .maj_bit_o  (maj_bit),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;
    zero_d       = zero_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stop2_d      = stop2_q;
    prescale_d   = prescale_q;
    p_data_d     = p_data_q;
    dv_d         = 1'b0;
    pe_d         = 1'b0;
    se_d         = 1'b0;
    bd_d         = 1'b0;
    samp_en      = 1'b0;
    samp_restart = 1'b0;
    stop_err_now = stop_err_q;
    all_zero     = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d      = ST_START;
          samp_restart = 1'b1;
          bit_cnt_d    = '0;
          par_err_d    = 1'b0;
          stop_err_d   = 1'b0;
          zero_d       = 1'b1;
          par_en_d     = PAR_EN;
          par_typ_d    = PAR_TYP;
          stop2_d      = STOP2;
          prescale_d   = (Prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                         PRESCALE_W'(MIN_PRESCALE) : Prescale;
        end
      end

      ST_START: begin
        samp_en = 1'b1;
        if (maj_valid && maj_bit) begin
          state_d      = ST_IDLE;
          samp_restart = 1'b1;
        end else if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        samp_en = 1'b1;
        if (maj_valid) begin
          shift_d = {maj_bit, shift_q[DATA_W-1:1]};
          zero_d  = zero_q & ~maj_bit;
        end
        if (bit_done) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        samp_en = 1'b1;
        if (maj_valid) begin
          par_err_d = maj_bit != ((^shift_q) ^ par_typ_q);
          zero_d    = zero_q & ~maj_bit;
        end
        if (bit_done) state_d = ST_STOP;
      end

      ST_STOP: begin
        samp_en = 1'b1;
        if (maj_valid) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            stop_err_d = stop_err_q | ~maj_bit;
            zero_d     = zero_q & ~maj_bit;
          end else begin
            // Resolve at the final stop's decision point so the next start
            // edge can be caught inside the remainder of this stop bit.
            stop_err_now = stop_err_q | ~maj_bit;
            all_zero     = stop2_q ? zero_q : (zero_q & ~maj_bit);
            dv_d         = !par_err_q && !stop_err_now;
            pe_d         = par_err_q;
            se_d         = stop_err_now;
            bd_d         = stop_err_now & all_zero;
            if (dv_d) p_data_d = shift_q;
            state_d      = stop_err_now ? ST_WAIT_IDLE : ST_IDLE;
            samp_restart = 1'b1;
          end
        end else if (bit_done) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        samp_en = 1'b1;
        if (!rx_s) begin
          samp_restart = 1'b1;
        end else if (bit_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      zero_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      prescale_q <= PRESCALE_W'(MIN_PRESCALE);
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      bd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      zero_q     <= zero_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      prescale_q <= prescale_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      bd_q       <= bd_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_Error   = se_q;
  assign Break_Det    = bd_q;
  assign Busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg : directed + randomized frames against a frame-level model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7;
  logic       par_en, par_typ, stop2;
  logic [5:0] prescale;

  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, se8, bd8, busy8;
  logic       dv7, pe7, se7, bd7, busy7;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_W(8), .PRESCALE_W(6), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .Prescale(prescale), .P_DATA(pd8), .Data_valid(dv8),
    .Parity_Error(pe8), .Stop_Error(se8), .Break_Det(bd8), .Busy(busy8)
  );

  uart_rx_cfg #(.DATA_W(7), .PRESCALE_W(6), .SYNC_STAGES(2)) dut7 (
    .clk(clk), .rst(rst), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .Prescale(prescale), .P_DATA(pd7), .Data_valid(dv7),
    .Parity_Error(pe7), .Stop_Error(se7), .Break_Det(bd7), .Busy(busy7)
  );

  typedef struct packed {
    logic       u;
    logic       dv;
    logic       pe;
    logic       se;
    logic       bd;
    logic [8:0] data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [8:0] exp_pdata [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Every cycle with any result pulse becomes one observed event.
  always @(negedge clk) begin
    if (dv8 | pe8 | se8 | bd8)
      obs_q.push_back(ev_t'({1'b0, dv8, pe8, se8, bd8, dv8 ? {1'b0, pd8} : 9'd0}));
    if (dv7 | pe7 | se7 | bd7)
      obs_q.push_back(ev_t'({1'b1, dv7, pe7, se7, bd7, dv7 ? {2'b0, pd7} : 9'd0}));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int u, input logic b);
    if (u == 0) rx8 = b;
    else        rx7 = b;
  endtask

  task automatic drive(input int u, input logic b, input int cycles);
    set_rx(u, b);
    tick(cycles);
  endtask

  function automatic logic [5:0] pick_p();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Builds the serial frame from the framing rules and records the outcome
  // the receiver must report for it.
  task automatic send_frame(input int u, input logic [8:0] data, input bit pen,
                            input bit ptyp, input bit s2, input int p,
                            input bit flip, input bit bs1, input bit bs2,
                            input bit scramble);
    int         dw   = (u == 0) ? 8 : 7;
    logic [8:0] d    = data & ((u == 0) ? 9'h0FF : 9'h07F);
    logic       pbit = (^d) ^ ptyp ^ flip;
    ev_t        e;
    par_en   = pen;
    par_typ  = ptyp;
    stop2    = s2;
    prescale = 6'(p);
    drive(u, 1'b0, p);
    if (scramble) begin
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      stop2    = 1'($urandom_range(0, 1));
      prescale = pick_p();
    end
    for (int i = 0; i < dw; i++) drive(u, d[i], p);
    if (pen) drive(u, pbit, p);
    drive(u, !bs1, p);
    if (s2) drive(u, !bs2, p);
    set_rx(u, 1'b1);
    e.u    = 1'(u);
    e.pe   = pen & flip;
    e.se   = bs1 | (s2 & bs2);
    e.dv   = !e.pe && !e.se;
    e.bd   = e.se && (d == 9'd0) && (!pen || !pbit) && bs1;
    e.data = e.dv ? d : 9'd0;
    exp_q.push_back(e);
    if (e.dv) exp_pdata[u] = d;
  endtask

  task automatic settle(input int u, input int idle);
    tick(idle);
    chk("event count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("event {u,dv,pe,se,bd,data}", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    chk("P_DATA dut8", 32'(pd8), 32'(exp_pdata[0]));
    chk("P_DATA dut7", 32'(pd7), 32'(exp_pdata[1]));
    chk("Busy after frame", 32'(u == 0 ? busy8 : busy7), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt, u, p;
    bit         saw, pen, s2, ptyp, flip, bs1, bs2, scr;
    logic [8:0] d;

    rst = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd8;
    exp_pdata[0] = 9'd0; exp_pdata[1] = 9'd0;
    tick(3);
    chk("reset outs dut8", 32'({dv8, pe8, se8, bd8, busy8, pd8}), 32'd0);
    chk("reset outs dut7", 32'({dv7, pe7, se7, bd7, busy7, pd7}), 32'd0);
    @(negedge clk); rst = 1'b1;
    tick(5);

    // 8-bit, P=8, even parity, 0x55
    send_frame(0, 9'h55, 1, 0, 0, 8, 0, 0, 0, 0);
    settle(0, 24);

    // 8-bit, P=16, odd parity with flipped parity bit on 0xA3
    send_frame(0, 9'hA3, 1, 1, 0, 16, 1, 0, 0, 0);
    settle(0, 40);

    // 7-bit, P=32, two stop bits, back-to-back, then bad second stop
    send_frame(1, 9'h3C, 0, 0, 1, 32, 0, 0, 0, 0);
    send_frame(1, 9'h41, 0, 0, 1, 32, 0, 0, 0, 0);
    settle(1, 72);
    send_frame(1, 9'h2A, 0, 0, 1, 32, 0, 0, 1, 0);
    settle(1, 72);

    // 3-cycle glitch at P=8 must be rejected
    prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
    drive(0, 1'b0, 3);
    set_rx(0, 1'b1);
    saw = (busy8 === 1'b1);
    cnt = saw ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy8) begin saw = 1'b1; cnt++; end
      else if (saw) break;
    end
    chk("glitch start detected", 32'(saw), 32'd1);
    chk("glitch busy <= P/2+2 cycles", 32'(cnt <= 6), 32'd1);
    settle(0, 10);
    send_frame(0, 9'h12, 0, 0, 0, 8, 0, 0, 0, 0);
    settle(0, 24);

    // line held low 3 frame times at P=16 with parity
    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd16;
    drive(0, 1'b0, 3 * 11 * 16);
    chk("break busy while held", 32'(busy8), 32'd1);
    chk("break single event", 32'(obs_q.size()), 32'd1);
    exp_q.push_back(ev_t'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0}));
    drive(0, 1'b1, 12);
    chk("wait-idle holds before 16 highs", 32'(busy8), 32'd1);
    cnt = 0;
    while (busy8 && cnt < 20) begin tick(1); cnt++; end
    chk("wait-idle released", 32'(busy8), 32'd0);
    settle(0, 8);
    send_frame(0, 9'h7E, 1, 0, 0, 16, 0, 0, 0, 0);
    settle(0, 40);

    // reset in the middle of data bits of 0xFF
    prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 24);
    chk("busy mid-frame", 32'(busy8), 32'd1);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("mid-frame reset dut8", 32'({dv8, pe8, se8, bd8, busy8, pd8}), 32'd0);
    chk("mid-frame reset dut7", 32'({dv7, pe7, se7, bd7, busy7, pd7}), 32'd0);
    exp_pdata[0] = 9'd0; exp_pdata[1] = 9'd0;
    @(negedge clk); rst = 1'b1;
    tick(20);
    settle(0, 1);
    send_frame(0, 9'h01, 0, 0, 0, 8, 0, 0, 0, 0);
    settle(0, 24);

    // randomized frames with random config, errors and mid-frame config churn
    for (int k = 0; k < 14; k++) begin
      u    = int'($urandom_range(0, 1));
      d    = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      p    = int'(pick_p());
      flip = pen && ($urandom_range(0, 3) == 0);
      bs1  = ($urandom_range(0, 4) == 0);
      bs2  = s2 && ($urandom_range(0, 4) == 0);
      scr  = 1'($urandom_range(0, 1));
      send_frame(u, d, pen, ptyp, s2, p, flip, bs1, bs2, scr);
      settle(u, 2 * p + 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised, runtime-configurable UART receiver; successor to the fixed 8-bit single-stop receiver.
- Adds:
  - DATA_W-bit words
  - one or two stop bits
  - an input synchroniser
  - 3-sample majority voting
  - false-start rejection
  - break detection
  - wait-for-idle recovery after framing errors
- Sits between the pad-side serial input and the byte-consuming logic, clocked at Prescale x baud.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- PRESCALE_W, 6, width of Prescale input.
- SYNC_STAGES, 2, flops in RX_IN synchroniser; legal 2..3.

Ports:
- clk  in  1  oversampling clock (Prescale x baud).
- rst  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line; idle high, LSB first.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits expected.
- Prescale  in  PRESCALE_W  oversampling ratio; legal 8, 16, 32.
- P_DATA  out  DATA_W  last correctly received word.
- Data_valid  out  1  one-cycle pulse, word good.
- Parity_Error  out  1  one-cycle pulse, parity mismatch.
- Stop_Error  out  1  one-cycle pulse, a stop bit sampled 0.
- Break_Det  out  1  one-cycle pulse, all-zero frame including stop.
- Busy  out  1  high from start detection until return to IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; synchroniser flops=1.
  - All counters=0, P_DATA=0.
  - Data_valid, Parity_Error, Stop_Error, Break_Det and Busy all 0.
- Synchroniser:
  - RX_IN passes through SYNC_STAGES flops; all sampling uses the synchronised bit rx_s.
- Configuration latch:
  - PAR_EN, PAR_TYP, STOP2 and Prescale are captured on the start-detect cycle.
  - Changes mid-frame have no effect until the next frame.
- Bit timing:
  - edge_cnt runs 0..Prescale-1 per bit, then wraps and bit_cnt increments.
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1 (P = latched Prescale).
  - The bit value is the majority of the 3 samples, decided at edge_cnt = P/2+1.
- State machine:
  - IDLE -> START when rx_s=0; edge_cnt=0 on entry; Busy=1.
  - START:
    - Majority 1 = false start -> IDLE; no output pulses, edge_cnt cleared.
    - Majority 0 -> DATA at bit end.
  - DATA:
    - DATA_W bits shifted LSB first into the shift register.
    - After bit DATA_W-1: -> PARITY if PAR_EN, else -> STOP.
  - PARITY:
    - Compares the sampled bit to (^data) XOR PAR_TYP; the mismatch flag is held.
  - STOP:
    - First stop bit; if STOP2 the second stop bit is also sampled.
    - Any stop sample of 0 sets the stop-error flag.
    - The frame is resolved at the majority point of the final stop bit; the remainder of the stop bit is not waited for, which allows back-to-back frames.
  - Resolve (1 cycle after the final-stop majority point):
    - No errors: P_DATA <= shift register; Data_valid=1.
    - Parity error: Parity_Error=1; P_DATA unchanged.
    - Stop error: Stop_Error=1; P_DATA unchanged.
    - Both errors pulse together when both occur; Data_valid is 0.
    - Break_Det=1 together with Stop_Error when all data bits, the parity bit (if enabled) and the first stop bit were 0.
    - Next state: no stop error -> IDLE; stop error -> WAIT_IDLE.
  - WAIT_IDLE:
    - Stays until rx_s=1 for one full bit time (P consecutive cycles), then -> IDLE.
    - Prevents re-triggering during a held break.
- Busy=0 in IDLE only.
- Latency: Data_valid is asserted P/2+2 clk after the start of the final stop bit on rx_s, plus SYNC_STAGES.
- Prescale illegal (not 8/16/32): behaviour unspecified; the bench must not drive it.
- Reset mid-frame: immediate return to the reset state; the partial word is discarded with no pulses.

Decomposition:
- Shared package uart_rx_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - MIN_PRESCALE=8
  - legal DATA_W range constants
- One sub-module, uart_rx_sampler:
  - edge counter, 3-sample capture, majority output and bit_done strobe.
  - Inputs: Prescale, enable, restart.

Test Plan:
- DATA_W=8, P=8, PAR_EN=1 even, STOP2=0, frame 0x55 -> one Data_valid pulse, P_DATA=0x55, no error pulses.
- DATA_W=8, P=16, odd parity, parity bit deliberately flipped on 0xA3 -> Parity_Error pulse, Data_valid=0, P_DATA retains previous 0x55.
- DATA_W=7, P=32, no parity, STOP2=1, 0x3C then immediate second frame 0x41 -> two Data_valid pulses, P_DATA 0x3C then 0x41; second stop bit driven 0 on a third frame -> Stop_Error.
- P=8, RX_IN low for 3 clk then high (glitch) -> no pulses, Busy returns 0 within P/2+2 clk, next valid frame 0x12 received correctly.
- P=16, PAR_EN=1, line held low 3 frame times then released -> exactly one Stop_Error+Break_Det pulse, no further pulses until 16 high cycles, then frame 0x7E -> Data_valid.
- Assert rst mid-DATA of frame 0xFF -> all outputs 0 immediately, no pulse; following frame 0x01 received correctly.
